// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the M-extension sequencer.
//   op_e       - funct3 encodings of the eight RV32M operations
//   state_e    - sequencer FSM states
//   WDOG_LIMIT - cycles allowed in WAIT/DRAIN before the core is presumed hung
//   INT_MIN, ALL_ONES - constants used by the divide corner cases
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  localparam logic [5:0]  WDOG_LIMIT = 6'd40;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES   = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: purely combinational sign handling around the unsigned core.
// Request side (from the live request):
//   op, rs1, rs2      -> mag_a, mag_b (unsigned magnitudes), core_mode,
//                        neg_flag (result must be negated), corner/corner_data
//                        (divide-by-zero and signed overflow bypass the core)
// Result side (from the registered request):
//   fix_op, fix_neg, core_out -> fix_data (final 32-bit architectural result)
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        core_mode,
  output logic        neg_flag,
  output logic        corner,
  output logic [31:0] corner_data,
  input  op_e         fix_op,
  input  logic        fix_neg,
  input  logic [63:0] core_out,
  output logic [31:0] fix_data
);

  logic        a_signed;
  logic        b_signed;
  logic        div_zero;
  logic        div_ovf;
  logic [63:0] prod_fix;
  logic [31:0] quot;
  logic [31:0] rem;

  // Magnitude formation, negation flag and bypass detection for a new request.
  // The magnitude of 0x80000000 is 0x80000000, which is correct when read unsigned.
  always_comb begin
    a_signed  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    mag_a     = (a_signed && rs1[31]) ? (~rs1 + 32'd1) : rs1;
    mag_b     = (b_signed && rs2[31]) ? (~rs2 + 32'd1) : rs2;
    core_mode = op[2];

    case (op)
      OP_MULH, OP_DIV:   neg_flag = rs1[31] ^ rs2[31];
      OP_MULHSU, OP_REM: neg_flag = rs1[31];
      default:           neg_flag = 1'b0;
    endcase

    div_zero = op[2] && (rs2 == 32'd0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
    corner   = div_zero || div_ovf;

    corner_data = 32'd0;
    if (div_zero) begin
      corner_data = ((op == OP_DIV) || (op == OP_DIVU)) ? ALL_ONES : rs1;
    end else if (div_ovf) begin
      corner_data = (op == OP_DIV) ? INT_MIN : 32'd0;
    end
  end

  // Post-correction of the unsigned core result. High-half multiplies need the
  // full 64-bit negation so the borrow from the low half reaches the upper word.
  always_comb begin
    prod_fix = fix_neg ? (~core_out + 64'd1) : core_out;
    quot     = core_out[31:0];
    rem      = core_out[63:32];
    case (fix_op)
      OP_MUL:            fix_data = core_out[31:0];
      OP_MULH, OP_MULHSU: fix_data = prod_fix[63:32];
      OP_MULHU:          fix_data = core_out[63:32];
      OP_DIV:            fix_data = fix_neg ? (~quot + 32'd1) : quot;
      OP_DIVU:           fix_data = quot;
      OP_REM:            fix_data = fix_neg ? (~rem + 32'd1) : rem;
      OP_REMU:           fix_data = rem;
      default:           fix_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer between the EX stage and an iterative unsigned
// multiply/divide core.
//   clk, rst_n                     - clock, asynchronous active-low reset
//   req_valid/req_ready, op, rs1, rs2 - request from EX (op in funct3 encoding)
//   flush                          - kill the in-flight operation
//   stall_o                        - hold the pipeline
//   resp_valid, resp_data          - one-cycle result strobe and result
//   core_valid, core_mode, core_a, core_b - start command to the core
//   core_ready, core_out           - core completion (mult: product, div: {rem, quot})
//   core_timeout                   - one-cycle watchdog error pulse
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall_o,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        core_valid,
  output logic        core_mode,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_ready,
  input  logic [63:0] core_out,
  output logic        core_timeout
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [31:0] a_q, b_q, resp_q;
  logic        mode_q, neg_q;
  logic [5:0]  wdog_q;

  logic [31:0] mag_a, mag_b, corner_data, fix_data;
  logic        mode_c, neg_c, corner;
  logic        accept, load_req, load_corner, load_result, timeout;
  logic        in_wd_q, in_wd_d;

  muldiv_signfix u_signfix (
    .op          (op_e'(op)),
    .rs1         (rs1),
    .rs2         (rs2),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .core_mode   (mode_c),
    .neg_flag    (neg_c),
    .corner      (corner),
    .corner_data (corner_data),
    .fix_op      (op_q),
    .fix_neg     (neg_q),
    .core_out    (core_out),
    .fix_data    (fix_data)
  );

  // rst_n gates req_ready so it reads 0 while reset is held, not just after.
  assign req_ready    = rst_n && (state_q == S_IDLE) && !flush;
  assign resp_valid   = (state_q == S_RESP) && !flush;
  assign resp_data    = resp_q;
  assign core_valid   = (state_q == S_LAUNCH);
  assign core_mode    = mode_q;
  assign core_a       = a_q;
  assign core_b       = b_q;
  assign core_timeout = timeout;
  assign stall_o      = accept || (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                        (state_q == S_DRAIN);

  // Next-state logic. The core cannot abort, so a flush while it is busy parks
  // in DRAIN until core_ready; a flush coinciding with core_ready goes straight
  // home. A result arriving on the watchdog's last cycle still wins.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    load_req    = 1'b0;
    load_corner = 1'b0;
    load_result = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (corner) begin
            load_corner = 1'b1;
            state_d     = S_RESP;
          end else begin
            load_req = 1'b1;
            state_d  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (core_ready) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            load_result = 1'b1;
            state_d     = S_RESP;
          end
        end else if (wdog_q == WDOG_LIMIT) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP: state_d = S_IDLE;
      S_DRAIN: begin
        if (core_ready) begin
          state_d = S_IDLE;
        end else if (wdog_q == WDOG_LIMIT) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_wd_q = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign in_wd_d = (state_d == S_WAIT) || (state_d == S_DRAIN);

  // State, request capture, result capture and watchdog. The watchdog keeps
  // counting across WAIT->DRAIN and clears on any exit from that pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      mode_q  <= 1'b0;
      neg_q   <= 1'b0;
      resp_q  <= 32'd0;
      wdog_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      if (load_req) begin
        op_q   <= op_e'(op);
        a_q    <= mag_a;
        b_q    <= mag_b;
        mode_q <= mode_c;
        neg_q  <= neg_c;
      end
      if (load_corner) begin
        resp_q <= corner_data;
      end else if (load_result) begin
        resp_q <= fix_data;
      end
      wdog_q <= (in_wd_q && in_wd_d) ? (wdog_q + 6'd1) : 6'd0;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. A behavioural iterative
// core answers core_valid after a programmable latency; results are compared
// against a reference computed with plain signed/unsigned arithmetic.
module tb_muldiv_seq;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        flush = 1'b0;
  logic        stall_o;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        core_valid;
  logic        core_mode;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_ready;
  logic [63:0] core_out;
  logic        core_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  int   core_lat  = 1;
  logic core_hold = 1'b0;

  muldiv_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .op           (op),
    .rs1          (rs1),
    .rs2          (rs2),
    .flush        (flush),
    .stall_o      (stall_o),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .core_valid   (core_valid),
    .core_mode    (core_mode),
    .core_a       (core_a),
    .core_b       (core_b),
    .core_ready   (core_ready),
    .core_out     (core_out),
    .core_timeout (core_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural iterative core: unsigned multiply or divide, answers after
  // core_lat cycles, freezes while core_hold is set, shares rst_n.
  logic [63:0] cm_a, cm_b;
  logic        cm_mode, cm_busy;
  int          cm_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_busy    <= 1'b0;
      cm_cnt     <= 0;
      cm_a       <= 64'd0;
      cm_b       <= 64'd0;
      cm_mode    <= 1'b0;
      core_ready <= 1'b0;
      core_out   <= 64'd0;
    end else begin
      core_ready <= 1'b0;
      if (core_valid) begin
        cm_busy <= 1'b1;
        cm_cnt  <= core_lat;
        cm_a    <= {32'd0, core_a};
        cm_b    <= {32'd0, core_b};
        cm_mode <= core_mode;
      end else if (cm_busy && !core_hold) begin
        if (cm_cnt <= 1) begin
          core_ready <= 1'b1;
          cm_busy    <= 1'b0;
          core_out   <= cm_mode ? {cm_a[31:0] % cm_b[31:0], cm_a[31:0] / cm_b[31:0]}
                                : cm_a * cm_b;
        end else begin
          cm_cnt <= cm_cnt - 1;
        end
      end
    end
  end

  // Architectural RV32M result computed with 64-bit host arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     r;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      MUL:    begin r = ua * ub;            return r[31:0];  end
      MULH:   begin r = sa * sb;            return r[63:32]; end
      MULHSU: begin r = sa * longint'(ub);  return r[63:32]; end
      MULHU:  begin r = ua * ub;            return r[63:32]; end
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        r = sa / sb;
        return r[31:0];
      end
      DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        r = sa % sb;
        return r[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_bypass(input logic [2:0] o, input logic [31:0] a, b);
    return (o[2] && (b == 32'd0)) ||
           (((o == DIV) || (o == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to its response, checking the data,
  // the number of core launches and the response timing.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input int lat, input string tag);
    int          n_cv = 0;
    int          ready_at = -1;
    int          resp_at = -1;
    logic [31:0] got = 32'd0;
    logic        byp = is_bypass(o, a, b);
    core_lat = lat;
    @(negedge clk);
    req_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    #1;
    check_output({tag, "/req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
    for (int i = 0; i < 100; i++) begin
      if (core_valid) n_cv++;
      if (core_ready && ready_at < 0) ready_at = i;
      if (resp_valid) begin
        resp_at = i;
        got = resp_data;
        break;
      end
      @(negedge clk);
    end
    check_output({tag, "/resp_seen"}, 64'(resp_at >= 0), 64'd1);
    check_output({tag, "/data"}, 64'(got), 64'(ref_model(o, a, b)));
    check_output({tag, "/core_valid_count"}, 64'(n_cv), byp ? 64'd0 : 64'd1);
    if (byp) check_output({tag, "/bypass_latency"}, 64'(resp_at), 64'd0);
    else     check_output({tag, "/resp_after_ready"}, 64'(resp_at - ready_at), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, observed hang, required completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int          rv, early, seen, to_at, tcnt;
    logic        idle_ready, idle_stall;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_output("reset/ctrl", {58'd0, req_ready, stall_o, resp_valid, core_valid,
                                core_mode, core_timeout}, 64'd0);
    check_output("reset/resp_data", 64'(resp_data), 64'd0);
    check_output("reset/core_ab", {core_a, core_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed results
    apply_stimulus(MULH, 32'hFFFF_FFFE, 32'd3, 3, "mulh_neg");
    apply_stimulus(DIV,  32'hFFFF_FFF9, 32'd2, 2, "div_neg7");
    apply_stimulus(REM,  32'hFFFF_FFF9, 32'd2, 4, "rem_neg7");
    apply_stimulus(DIVU, 32'd1234, 32'd0, 1, "divu_zero");
    apply_stimulus(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf");
    apply_stimulus(REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, "rem_ovf");
    apply_stimulus(REMU, 32'hDEAD_BEEF, 32'd0, 1, "remu_zero");

    // Flush five cycles into WAIT
    core_lat = 20;
    @(negedge clk);
    req_valid = 1'b1; op = MUL; rs1 = 32'd9; rs2 = 32'd11;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_output("flush/stall_in_drain", 64'(stall_o), 64'd1);
    rv = 0; early = 0; seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid) rv++;
      if (req_ready) early++;
      if (core_ready) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check_output("flush/core_ready_seen", 64'(seen), 64'd1);
    check_output("flush/no_resp", 64'(rv), 64'd0);
    check_output("flush/ready_low_in_drain", 64'(early), 64'd0);
    @(negedge clk);
    #1;
    check_output("flush/ready_after_drain", 64'(req_ready), 64'd1);
    apply_stimulus(MUL, 32'd6, 32'd7, 2, "mul_after_flush");

    // Watchdog: the core never answers
    core_hold = 1'b1;
    core_lat  = 1;
    @(negedge clk);
    req_valid = 1'b1; op = MUL; rs1 = 32'd3; rs2 = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    rv = 0; tcnt = 0; to_at = -1; idle_ready = 1'b0; idle_stall = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (core_timeout) begin
        tcnt++;
        if (to_at < 0) to_at = i;
      end
      if (resp_valid) rv++;
      if (to_at >= 0 && i == to_at + 1) begin
        idle_ready = req_ready;
        idle_stall = stall_o;
        break;
      end
      @(negedge clk);
    end
    check_output("wdog/timeout_cycle", 64'(to_at), 64'd41);
    check_output("wdog/pulse_width", 64'(tcnt), 64'd1);
    check_output("wdog/no_resp", 64'(rv), 64'd0);
    check_output("wdog/idle_ready", 64'(idle_ready), 64'd1);
    check_output("wdog/idle_stall", 64'(idle_stall), 64'd0);
    core_hold = 1'b0;

    // Reset in WAIT
    core_lat = 20;
    @(negedge clk);
    req_valid = 1'b1; op = DIVU; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("rst_wait/ctrl", {58'd0, req_ready, stall_o, resp_valid, core_valid,
                                   core_mode, core_timeout}, 64'd0);
    check_output("rst_wait/resp_data", 64'(resp_data), 64'd0);
    check_output("rst_wait/core_ab", {core_a, core_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(MULHSU, 32'hFFFF_FFFF, 32'd2, 3, "mulhsu_after_rst");

    // Randomized operations against the reference model
    for (int k = 0; k < 40; k++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        rb = 32'd0;
      end else if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (sel < 5) begin
        rb = $urandom_range(1, 20);
        if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      end
      apply_stimulus(ro, ra, rb, $urandom_range(1, 6), $sformatf("rand%0d_op%0d", k, ro));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
